aes_block_loader: RTL
=====================

AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 Parameter WORD_W, default 32: width of one input word.
REQ-002 Parameter WORDS, default 4: words per 128-bit group (WORD_W*WORDS SHALL equal 128).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 in_valid  input  1  source presents in_data.
REQ-006 in_ready  output  1  loader can accept a word this cycle.
REQ-007 in_data  input  32  input word, most-significant word of a group first.
REQ-008 in_sel  input  1  group type, 0=plaintext, 1=key; sampled on a group's first accepted word only.
REQ-009 flush  input  1  synchronous discard of any partial group.
REQ-010 text_out  output  128  committed plaintext block to the encryption datapath.
REQ-011 key_out  output  128  committed cipher key to key expansion.
REQ-012 out_valid  output  1  text_out/key_out pair is ready for the encryption core.
REQ-013 out_ready  input  1  encryption core consumes the pair.
REQ-014 key_loaded  output  1  a complete key has been committed since reset.
REQ-015 err  output  1  one-cycle pulse: plaintext group dropped because no key is loaded.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, ISSUE.
REQ-017 A word is accepted only when in_valid=1 and in_ready=1 on the same rising edge.
REQ-018 in_ready SHALL be 1 in IDLE and LOAD and 0 in ISSUE.
REQ-019 On the first accepted word in IDLE: latch in_sel, set word count to 1, and go to LOAD.
REQ-020 Word k (0-based) of a group SHALL occupy bits [127-32k -: 32] of the assembled block.
REQ-021 The 2-bit word counter SHALL wrap from 3 to 0 on the 4th accepted word, completing the group.
REQ-022 Key group completion: key_out SHALL update on that edge, key_loaded SHALL become 1, and the FSM SHALL return to IDLE; out_valid stays 0.
REQ-023 Text group completion with key_loaded=1: text_out SHALL update on that edge and the FSM SHALL enter ISSUE, so out_valid=1 in the next cycle (1-cycle latency from the 4th word).
REQ-024 Text group completion with key_loaded=0: the group SHALL be discarded, text_out is unchanged, err=1 for exactly the next cycle, and the FSM returns to IDLE.
REQ-025 text_out and key_out SHALL change only on group commit; partial groups are held in an internal shift register and are never visible.
REQ-026 In ISSUE, out_valid SHALL stay 1 with stable outputs until out_ready=1; on that edge the FSM goes to IDLE and in_ready=1 in the following cycle.
REQ-027 A flush in IDLE or LOAD SHALL clear the word counter and return to IDLE; key_out, text_out and key_loaded are kept.
REQ-028 If flush coincides with an accepted word, flush SHALL win and the word is discarded.
REQ-029 A flush in ISSUE SHALL be ignored, so a committed block is always delivered.
REQ-030 in_sel changes within a group SHALL be ignored.

Reset
REQ-031 While rst=0: FSM=IDLE, counter=0, text_out=0, key_out=0, shift register=0, out_valid=0, key_loaded=0, err=0; in_ready=1 on the first cycle after release.
REQ-032 Reset asserted mid-group or in ISSUE SHALL abandon all in-flight data with no out_valid pulse.

Structure
REQ-033 Shared package aes_pkg SHALL hold AES_WORD_W=32, AES_BLOCK_W=128, AES_WORDS=4 and the loader state enum.
REQ-034 One sub-module, aes_word_packer (a 4x32 shift-in collector with a count/complete flag), SHALL be instantiated; all other logic stays in aes_block_loader.

Verification
REQ-035 Key 00000000 x4 (in_sel=1), then text 00000101,03030707,0f0f1f1f,3f3f7f7f (in_sel=0) -> key_out=0, text_out=128'h00000101030307070f0f1f1f3f3f7f7f, out_valid=1 one cycle after the 4th text word.
REQ-036 Text group with no prior key -> err pulses for 1 cycle, out_valid stays 0, text_out stays 0.
REQ-037 out_ready held 0 for 5 cycles in ISSUE -> out_valid and outputs stable, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-038 Flush after 2 key words, then 4 key words 11111111,22222222,33333333,44444444 -> key_out=128'h11111111222222223333333344444444.
REQ-039 Flush on the same edge as the 4th text word -> no commit, no out_valid, FSM in IDLE.
REQ-040 rst=0 asserted mid-group and in ISSUE -> all outputs 0 at once (asynchronous), key_loaded=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES block loader.
package aes_pkg;

  localparam int AES_WORD_W  = 32;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORDS   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Shift-in collector: gathers WORDS words, first word ending in the top slot,
// and flags the edge on which the last word of a group arrives.
module aes_word_packer
  import aes_pkg::*;
#(
  parameter int WORD_W = AES_WORD_W,
  parameter int WORDS  = AES_WORDS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_shift,
  input  logic                      i_clear,
  input  logic [WORD_W-1:0]         i_word,
  output logic [WORD_W*WORDS-1:0]   o_block,
  output logic                      o_complete
);

  localparam int BLOCK_W = WORD_W * WORDS;
  localparam int CNT_W   = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  logic [BLOCK_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_count;
  logic [BLOCK_W-1:0] w_next_shift;

  // The block including the word arriving this cycle, so a commit can use it directly.
  assign w_next_shift = {r_shift[BLOCK_W-WORD_W-1:0], i_word};
  assign o_block      = w_next_shift;
  assign o_complete   = i_shift && (r_count == LAST_IDX);

  // Shift register and word counter; the counter wraps to zero on the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= {BLOCK_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_shift <= {BLOCK_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (i_shift) begin
      r_shift <= w_next_shift;
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_shift <= r_shift;
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Assembles 32-bit words into 128-bit key / plaintext groups and hands
// committed key+text pairs to the encryption core.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int WORD_W = AES_WORD_W,
  parameter int WORDS  = AES_WORDS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_sel,
  input  logic                      flush,
  output logic [WORD_W*WORDS-1:0]   text_out,
  output logic [WORD_W*WORDS-1:0]   key_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      key_loaded,
  output logic                      err
);

  localparam int BLOCK_W = WORD_W * WORDS;

  loader_state_t      r_state;
  loader_state_t      w_next_state;
  logic               r_sel;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_key_loaded;
  logic               r_err;
  logic [BLOCK_W-1:0] r_text;
  logic [BLOCK_W-1:0] r_key;

  logic               w_take;
  logic               w_clear;
  logic               w_complete;
  logic [BLOCK_W-1:0] w_block;
  logic               w_key_commit;
  logic               w_text_commit;
  logic               w_drop;

  // Flush beats a coinciding word; neither can happen while a block is issued.
  assign w_take  = in_valid && r_in_ready && !flush;
  assign w_clear = flush && r_in_ready;

  aes_word_packer #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_shift    (w_take),
    .i_clear    (w_clear),
    .i_word     (in_data),
    .o_block    (w_block),
    .o_complete (w_complete)
  );

  // Next-state and commit decisions.
  always_comb begin
    w_next_state  = r_state;
    w_key_commit  = 1'b0;
    w_text_commit = 1'b0;
    w_drop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_next_state = LOAD;
        end else begin
          w_next_state = IDLE;
        end
      end
      LOAD: begin
        if (flush) begin
          w_next_state = IDLE;
        end else if (w_complete) begin
          if (r_sel) begin
            w_key_commit = 1'b1;
            w_next_state = IDLE;
          end else if (r_key_loaded) begin
            w_text_commit = 1'b1;
            w_next_state  = ISSUE;
          end else begin
            w_drop       = 1'b1;
            w_next_state = IDLE;
          end
        end else begin
          w_next_state = LOAD;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = ISSUE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, handshake flags and committed blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_key_loaded <= 1'b0;
      r_err        <= 1'b0;
      r_text       <= {BLOCK_W{1'b0}};
      r_key        <= {BLOCK_W{1'b0}};
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != ISSUE);
      r_out_valid <= (w_next_state == ISSUE);
      r_err       <= w_drop;
      if (r_state == IDLE && w_take) begin
        r_sel <= in_sel;
      end else begin
        r_sel <= r_sel;
      end
      if (w_key_commit) begin
        r_key        <= w_block;
        r_key_loaded <= 1'b1;
      end else begin
        r_key        <= r_key;
        r_key_loaded <= r_key_loaded;
      end
      if (w_text_commit) begin
        r_text <= w_block;
      end else begin
        r_text <= r_text;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign key_loaded = r_key_loaded;
  assign err        = r_err;
  assign text_out   = r_text;
  assign key_out    = r_key;

endmodule
